// File: rtl/snake_tail_eraser.sv
// snake_tail_eraser: consumer end of the snake-body coordinate FIFO.
// On each game step it pops the tail segment and issues a one-pixel clear
// request to the framebuffer arbiter. Pending growth credits suppress the
// pop, so the snake lengthens by one segment per credit.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   tick                one-cycle game-step pulse
//   grow                one-cycle food-eaten pulse, adds a growth credit
//   fifo_data/empty     show-ahead FIFO head word and empty flag
//   fifo_read           one-cycle pop strobe
//   fb_req/x/y/color    erase write request to the framebuffer arbiter
//   fb_ack              arbiter accept, one cycle
//   busy                high whenever the FSM is not idle
//   underflow, overrun  sticky error flags, cleared only by reset
//   erase_count         acked-erase counter (only with SNAKE_TAIL_ERASE_CNT_EN)
//
// Build option: define SNAKE_TAIL_ERASE_CNT_EN to add erase_count.

module snake_tail_eraser #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned GROW_W     = 4,
  parameter logic [2:0]  BG_COLOR   = 3'b000
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    tick,
  input  logic                    grow,
  input  logic [DATA_WIDTH-1:0]   fifo_data,
  input  logic                    fifo_empty,
  output logic                    fifo_read,
  output logic                    fb_req,
  output logic [DATA_WIDTH/2-1:0] fb_x,
  output logic [DATA_WIDTH/2-1:0] fb_y,
  output logic [2:0]              fb_color,
  input  logic                    fb_ack,
  output logic                    busy,
  output logic                    underflow,
`ifdef SNAKE_TAIL_ERASE_CNT_EN
  output logic [15:0]             erase_count,
`endif
  output logic                    overrun
);

  localparam int unsigned HALF_W = DATA_WIDTH / 2;
  localparam logic [GROW_W-1:0] GROW_MAX = {GROW_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POP   = 2'd1,
    S_ERASE = 2'd2
  } state_t;

  state_t                state;
  logic [GROW_W-1:0]     grow_cnt;
  logic [GROW_W-1:0]     grow_cnt_nxt;
  logic [DATA_WIDTH-1:0] tail;
  logic                  credit_avail;
  logic                  consume;

  // A credit is available if one is banked or one arrives this cycle.
  assign credit_avail = (grow_cnt != '0) || grow;
  assign consume      = tick && (state == S_IDLE) && credit_avail;

  // Growth-credit update: a grow coincident with a consumed tick nets to zero.
  always_comb begin
    grow_cnt_nxt = grow_cnt;
    if (consume) begin
      if (!grow) grow_cnt_nxt = grow_cnt - GROW_W'(1);
    end else if (grow && (grow_cnt != GROW_MAX)) begin
      grow_cnt_nxt = grow_cnt + GROW_W'(1);
    end
  end

  // FSM with registered strobes; outputs mirror the state they belong to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      grow_cnt  <= '0;
      tail      <= '0;
      fifo_read <= 1'b0;
      fb_req    <= 1'b0;
      busy      <= 1'b0;
      underflow <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      grow_cnt <= grow_cnt_nxt;
      case (state)
        S_IDLE: begin
          if (tick && !credit_avail) begin
            if (fifo_empty) begin
              underflow <= 1'b1;
            end else begin
              state     <= S_POP;
              fifo_read <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        S_POP: begin
          // FIFO word is still the show-ahead head during the pop cycle.
          tail      <= fifo_data;
          fifo_read <= 1'b0;
          fb_req    <= 1'b1;
          state     <= S_ERASE;
          if (tick) overrun <= 1'b1;
        end
        S_ERASE: begin
          if (tick) overrun <= 1'b1;
          if (fb_ack) begin
            fb_req <= 1'b0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          fifo_read <= 1'b0;
          fb_req    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign fb_x     = tail[DATA_WIDTH-1:HALF_W];
  assign fb_y     = tail[HALF_W-1:0];
  assign fb_color = BG_COLOR;

`ifdef SNAKE_TAIL_ERASE_CNT_EN
  // Counts accepted erase writes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      erase_count <= '0;
    end else if ((state == S_ERASE) && fb_ack) begin
      erase_count <= erase_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snake_tail_eraser.sv
// Directed testbench for snake_tail_eraser with a small show-ahead FIFO model.
// Inputs change and outputs are sampled 1 time unit after the rising edge.

module tb_snake_tail_eraser;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tick;
  logic        grow;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_read;
  logic        fb_req;
  logic [7:0]  fb_x;
  logic [7:0]  fb_y;
  logic [2:0]  fb_color;
  logic        fb_ack;
  logic        busy;
  logic        underflow;
  logic        overrun;
`ifdef SNAKE_TAIL_ERASE_CNT_EN
  logic [15:0] erase_count;
`endif

  int errors = 0;
  int checks = 0;

  // FIFO model: tasks own the write side, the clocked block owns the read side.
  logic [15:0] mem [0:7];
  logic [2:0]  wr = 3'd0;
  logic [2:0]  rd = 3'd0;
  int          pop_cnt = 0;

  assign fifo_empty = (rd == wr);
  assign fifo_data  = mem[rd];

  always @(posedge clk) begin
    if (fifo_read && !fifo_empty) rd <= rd + 3'd1;
    if (fifo_read) pop_cnt <= pop_cnt + 1;
  end

  always #5 clk = ~clk;

  snake_tail_eraser #(
    .DATA_WIDTH(16),
    .GROW_W    (4),
    .BG_COLOR  (3'b000)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tick       (tick),
    .grow       (grow),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fb_req     (fb_req),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .fb_color   (fb_color),
    .fb_ack     (fb_ack),
    .busy       (busy),
    .underflow  (underflow),
`ifdef SNAKE_TAIL_ERASE_CNT_EN
    .erase_count(erase_count),
`endif
    .overrun    (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr] = w;
    wr = wr + 3'd1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; tick = 1'b0; grow = 1'b0; fb_ack = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    step();
    step();
    checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL reset_fifo_read: got %b want 0", fifo_read); end
    checks++; if (fb_req !== 1'b0) begin errors++; $display("FAIL reset_fb_req: got %b want 0", fb_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({underflow, overrun} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {underflow, overrun}); end
    checks++; if ({fb_x, fb_y} !== 16'h0000) begin errors++; $display("FAIL reset_coords: got %h want 0000", {fb_x, fb_y}); end
    checks++; if (fb_color !== 3'b000) begin errors++; $display("FAIL reset_color: got %b want 000", fb_color); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic_erase();
    int p0;
    push(16'h0A05);
    p0 = pop_cnt;
    tick = 1'b1;
    step();            // cycle 1
    tick = 1'b0;
    checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL basic_read_c1: got %b want 1", fifo_read); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_c1: got %b want 1", busy); end
    step();            // cycle 2
    checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL basic_read_c2: got %b want 0", fifo_read); end
    checks++; if (fb_req !== 1'b1) begin errors++; $display("FAIL basic_req_c2: got %b want 1", fb_req); end
    checks++; if (fb_x !== 8'h0A || fb_y !== 8'h05) begin errors++; $display("FAIL basic_xy: got %h,%h want 0a,05", fb_x, fb_y); end
    checks++; if (fb_color !== 3'b000) begin errors++; $display("FAIL basic_color: got %b want 000", fb_color); end
    step();            // cycle 3
    step();            // cycle 4
    checks++; if (fb_req !== 1'b1 || fb_x !== 8'h0A) begin errors++; $display("FAIL basic_hold_c4: got req=%b x=%h want 1,0a", fb_req, fb_x); end
    fb_ack = 1'b1;
    step();            // cycle 5
    fb_ack = 1'b0;
    checks++; if (fb_req !== 1'b0) begin errors++; $display("FAIL basic_req_c5: got %b want 0", fb_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_c5: got %b want 0", busy); end
    checks++; if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL basic_pops: got %0d want 1", pop_cnt - p0); end
    step();
  endtask

  task automatic test_grow_credits();
    int p0;
    push(16'h0101);
    push(16'h0202);
    grow = 1'b1; step(); grow = 1'b0; step();
    grow = 1'b1; step(); grow = 1'b0; step();
    p0 = pop_cnt;
    for (int t = 0; t < 2; t++) begin
      tick = 1'b1; step(); tick = 1'b0;
      checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL grow_skip_read%0d: got %b want 0", t, fifo_read); end
      step();
      checks++; if (fb_req !== 1'b0) begin errors++; $display("FAIL grow_skip_req%0d: got %b want 0", t, fb_req); end
    end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL grow_third_read: got %b want 1", fifo_read); end
    step();
    checks++; if (fb_req !== 1'b1 || fb_x !== 8'h01 || fb_y !== 8'h01) begin errors++; $display("FAIL grow_third_erase: got req=%b %h,%h want 1 01,01", fb_req, fb_x, fb_y); end
    fb_ack = 1'b1; step(); fb_ack = 1'b0;
    checks++; if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL grow_pops: got %0d want 1", pop_cnt - p0); end
    // drain the second word, which should be the next tail
    tick = 1'b1; step(); tick = 1'b0; step();
    checks++; if (fb_x !== 8'h02 || fb_y !== 8'h02) begin errors++; $display("FAIL grow_drain_xy: got %h,%h want 02,02", fb_x, fb_y); end
    fb_ack = 1'b1; step(); fb_ack = 1'b0; step();
  endtask

  task automatic test_grow_tick_same();
    int p0;
    push(16'h0303);
    p0 = pop_cnt;
    grow = 1'b1; tick = 1'b1; step(); grow = 1'b0; tick = 1'b0;
    checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL same_read: got %b want 0", fifo_read); end
    step();
    checks++; if (fb_req !== 1'b0) begin errors++; $display("FAIL same_req: got %b want 0", fb_req); end
    // credit count must still be zero: the next tick pops
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL same_next_read: got %b want 1", fifo_read); end
    step();
    checks++; if (fb_x !== 8'h03 || fb_y !== 8'h03) begin errors++; $display("FAIL same_xy: got %h,%h want 03,03", fb_x, fb_y); end
    fb_ack = 1'b1; step(); fb_ack = 1'b0; step();
    checks++; if (pop_cnt - p0 !== 1) begin errors++; $display("FAIL same_pops: got %0d want 1", pop_cnt - p0); end
  endtask

  task automatic test_saturation();
    int p0;
    push(16'h0404);
    for (int i = 0; i < 20; i++) begin
      grow = 1'b1; step(); grow = 1'b0;
    end
    step();
    p0 = pop_cnt;
    for (int t = 0; t < 15; t++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
    checks++; if (pop_cnt - p0 !== 0) begin errors++; $display("FAIL sat_skips: got %0d pops want 0", pop_cnt - p0); end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL sat_16th_read: got %b want 1", fifo_read); end
    step();
    checks++; if (fb_x !== 8'h04 || fb_req !== 1'b1) begin errors++; $display("FAIL sat_16th_erase: got req=%b x=%h want 1,04", fb_req, fb_x); end
    fb_ack = 1'b1; step(); fb_ack = 1'b0; step();
  endtask

  task automatic test_underflow();
    int p0;
    p0 = pop_cnt;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_before: got %b want 0", underflow); end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (fifo_read !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL uf_read: got read=%b busy=%b want 0,0", fifo_read, busy); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b want 1", underflow); end
    step(); step(); step();
    checks++; if (underflow !== 1'b1 || pop_cnt - p0 !== 0) begin errors++; $display("FAIL uf_sticky: got uf=%b pops=%0d want 1,0", underflow, pop_cnt - p0); end
  endtask

  task automatic test_overrun();
    int p0;
    push(16'h0505);
    push(16'h0606);
    p0 = pop_cnt;
    tick = 1'b1; step(); tick = 1'b0;   // POP
    step();                             // ERASE
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b want 0", overrun); end
    tick = 1'b1; step(); tick = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    step(); step();
    checks++; if (fb_req !== 1'b1 || fb_x !== 8'h05) begin errors++; $display("FAIL ovr_hold: got req=%b x=%h want 1,05", fb_req, fb_x); end
    fb_ack = 1'b1; step(); fb_ack = 1'b0;
    step(); step(); step();
    checks++; if (pop_cnt - p0 !== 1 || busy !== 1'b0) begin errors++; $display("FAIL ovr_one_pop: got pops=%0d busy=%b want 1,0", pop_cnt - p0, busy); end
    checks++; if (overrun !== 1'b1 || underflow !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got ovr=%b uf=%b want 1,1", overrun, underflow); end
  endtask

  task automatic test_reset_mid_erase();
    int p0;
    tick = 1'b1; step(); tick = 1'b0;   // pops 0606
    step();
    checks++; if (fb_req !== 1'b1 || fb_x !== 8'h06) begin errors++; $display("FAIL rst_pre_erase: got req=%b x=%h want 1,06", fb_req, fb_x); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (fb_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async_drop: got req=%b busy=%b want 0,0", fb_req, busy); end
    checks++; if (overrun !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rst_flags_clear: got ovr=%b uf=%b want 0,0", overrun, underflow); end
`ifdef SNAKE_TAIL_ERASE_CNT_EN
    checks++; if (erase_count !== 16'd0) begin errors++; $display("FAIL rst_erase_count: got %0d want 0", erase_count); end
`endif
    step();
    rstn = 1'b1;
    step();
    push(16'h0707);
    push(16'h0808);
    push(16'h0909);
    p0 = pop_cnt;
    for (int k = 7; k <= 9; k++) begin
      tick = 1'b1; step(); tick = 1'b0;
      checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL rst_next_read%0d: got %b want 1", k, fifo_read); end
      step();
      checks++; if (fb_x !== 8'(k) || fb_y !== 8'(k)) begin errors++; $display("FAIL rst_next_xy%0d: got %h,%h want %h", k, fb_x, fb_y, 8'(k)); end
      fb_ack = 1'b1; step(); fb_ack = 1'b0; step();
    end
    checks++; if (pop_cnt - p0 !== 3) begin errors++; $display("FAIL rst_pops: got %0d want 3", pop_cnt - p0); end
`ifdef SNAKE_TAIL_ERASE_CNT_EN
    checks++; if (erase_count !== 16'd3) begin errors++; $display("FAIL erase_count_3: got %0d want 3", erase_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_erase();
    test_grow_credits();
    test_grow_tick_same();
    test_saturation();
    test_underflow();
    test_overrun();
    test_reset_mid_erase();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
